pulse_period_monitor: RTL and testbench

Downstream consumer of the one-pulse-per-period FSM signal generator. Samples the generator's `sig` output, measures high time and full period of every complete pulse in clock cycles, and delivers each measurement over a valid/ready handshake. Flags lost results (back-pressure overrun) and stalled inputs (timeout). Used for on-chip self-check of the 1 s high / 3 s period timing pattern.

---
 rtl/pulse_period_monitor.sv | 158 +++++++++++++++
 tb/tb_pulse_period_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_monitor.sv
// pulse_period_monitor: measures the high time and full period of each
// complete pulse on sig_in (in clock cycles) and reports every measurement
// through a single-entry valid/ready output slot. It also flags dropped
// results (overrun) and abandoned measurements (timeout).
module pulse_period_monitor #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 400_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_high_cycles,
  output logic [CNT_W-1:0] m_period_cycles,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [1:0] WAIT_RISE = 2'd0;
  localparam logic [1:0] MEAS_HIGH = 2'd1;
  localparam logic [1:0] MEAS_LOW  = 2'd2;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync1_q, sig_s_q, sig_d_q;
  logic             rise, fall;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             timeout_q, timeout_d;
  logic             complete;

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] res_high_q, res_high_d;
  logic [CNT_W-1:0] res_period_q, res_period_d;
  logic             overrun_q, overrun_d;
  logic             handshake;

  // Synchroniser plus delay stage; all reset high so a signal already
  // high at reset does not produce a spurious rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sig_s_q <= 1'b1;
      sig_d_q <= 1'b1;
    end else begin
      sync1_q <= sig_in;
      sig_s_q <= sync1_q;
      sig_d_q <= sig_s_q;
    end
  end

  assign rise = sig_s_q & ~sig_d_q;
  assign fall = ~sig_s_q & sig_d_q;

  // Measurement FSM and cycle counters. A timeout in MEAS_HIGH wins over a
  // coincident fall; in MEAS_LOW a completing rise wins over the timeout.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    high_d    = high_q;
    timeout_d = 1'b0;
    complete  = 1'b0;
    case (state_q)
      WAIT_RISE: begin
        period_d = '0;
        if (rise) begin
          state_d  = MEAS_HIGH;
          period_d = CNT_ONE;
        end
      end
      MEAS_HIGH: begin
        if (period_q == TIMEOUT_C) begin
          state_d   = WAIT_RISE;
          period_d  = '0;
          timeout_d = 1'b1;
        end else begin
          period_d = period_q + CNT_ONE;
          if (fall) begin
            state_d = MEAS_LOW;
            high_d  = period_q;
          end
        end
      end
      MEAS_LOW: begin
        if (rise) begin
          complete = 1'b1;
          state_d  = MEAS_HIGH;
          period_d = CNT_ONE;
        end else if (period_q == TIMEOUT_C) begin
          state_d   = WAIT_RISE;
          period_d  = '0;
          timeout_d = 1'b1;
        end else begin
          period_d = period_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = WAIT_RISE;
        period_d = '0;
      end
    endcase
  end

  // Output slot: accept a completion when empty or draining this cycle,
  // otherwise drop it and set the sticky overrun flag.
  always_comb begin
    handshake    = valid_q & m_ready;
    valid_d      = valid_q;
    res_high_d   = res_high_q;
    res_period_d = res_period_q;
    overrun_d    = overrun_q;
    if (complete && (!valid_q || m_ready)) begin
      valid_d      = 1'b1;
      res_high_d   = high_q;
      res_period_d = period_q;
      overrun_d    = 1'b0;
    end else if (complete) begin
      overrun_d = 1'b1;
    end else if (handshake) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // State, counter and output-slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_RISE;
      period_q     <= '0;
      high_q       <= '0;
      timeout_q    <= 1'b0;
      valid_q      <= 1'b0;
      res_high_q   <= '0;
      res_period_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      high_q       <= high_d;
      timeout_q    <= timeout_d;
      valid_q      <= valid_d;
      res_high_q   <= res_high_d;
      res_period_q <= res_period_d;
      overrun_q    <= overrun_d;
    end
  end

  assign m_valid         = valid_q;
  assign m_high_cycles   = res_high_q;
  assign m_period_cycles = res_period_q;
  assign overrun         = overrun_q;
  assign timeout         = timeout_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Directed testbench for pulse_period_monitor: one DUT at the default
// timeout, one at TIMEOUT=20 for the abandon/boundary scenarios.
module tb_pulse_period_monitor;

  logic        clk = 1'b0;
  logic        rst, sig_in, m_ready;
  logic        m_valid, overrun, timeout;
  logic [31:0] m_high, m_period;

  logic        rst2, sig2, ready2;
  logic        valid2, ovr2, to2;
  logic [31:0] high2, period2;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pulse_period_monitor dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .m_valid(m_valid), .m_ready(m_ready),
    .m_high_cycles(m_high), .m_period_cycles(m_period), .overrun(overrun), .timeout(timeout)
  );

  pulse_period_monitor #(.CNT_W(32), .TIMEOUT(20)) dut_t (
    .clk(clk), .rst(rst2), .sig_in(sig2), .m_valid(valid2), .m_ready(ready2),
    .m_high_cycles(high2), .m_period_cycles(period2), .overrun(ovr2), .timeout(to2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic lvl, input int unsigned n);
    sig_in = lvl;
    repeat (n) tick();
  endtask

  task automatic hold2(input logic lvl, input int unsigned n);
    sig2 = lvl;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; sig_in = 1'b1; m_ready = 1'b0;
    repeat (10) tick();
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", m_valid); end
    n_vec++; if (m_high !== 32'd0) begin n_err++; $display("FAIL rst_high: got %0d want 0", m_high); end
    n_vec++; if (m_period !== 32'd0) begin n_err++; $display("FAIL rst_period: got %0d want 0", m_period); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %0b want 0", overrun); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %0b want 0", timeout); end
    rst = 1'b0;
  endtask

  task automatic test_first_result();
    hold(1'b0, 4);
    hold(1'b1, 5);
    hold(1'b0, 7);
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL partial_no_result: got %0b want 0", m_valid); end
    sig_in = 1'b1;
    tick(); tick();
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL first_latency_early: got %0b want 0", m_valid); end
    tick();
    n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %0b want 1", m_valid); end
    n_vec++; if (m_high !== 32'd5) begin n_err++; $display("FAIL first_high: got %0d want 5", m_high); end
    n_vec++; if (m_period !== 32'd12) begin n_err++; $display("FAIL first_period: got %0d want 12", m_period); end
    tick(); tick();
  endtask

  task automatic test_overrun();
    hold(1'b0, 7);
    sig_in = 1'b1;
    tick(); tick();
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early: got %0b want 0", overrun); end
    tick();
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %0b want 1", overrun); end
    n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid_held: got %0b want 1", m_valid); end
    hold(1'b0, 6);
    sig_in = 1'b1;
    tick(); tick(); tick();
    n_vec++; if (m_high !== 32'd5) begin n_err++; $display("FAIL ovr_high_stable: got %0d want 5", m_high); end
    n_vec++; if (m_period !== 32'd12) begin n_err++; $display("FAIL ovr_period_stable: got %0d want 12", m_period); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %0b want 1", overrun); end
    tick(); tick();
    hold(1'b0, 2);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL hs_valid_clear: got %0b want 0", m_valid); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL hs_overrun_clear: got %0b want 0", overrun); end
    hold(1'b0, 4);
  endtask

  task automatic test_back_to_back();
    sig_in = 1'b1;
    tick(); tick(); tick();
    n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first_valid: got %0b want 1", m_valid); end
    n_vec++; if (m_period !== 32'd12) begin n_err++; $display("FAIL b2b_first_period: got %0d want 12", m_period); end
    hold(1'b0, 4);
    sig_in = 1'b1;
    tick(); tick();
    m_ready = 1'b1;
    tick();
    n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid_kept: got %0b want 1", m_valid); end
    n_vec++; if (m_high !== 32'd3) begin n_err++; $display("FAIL b2b_high: got %0d want 3", m_high); end
    n_vec++; if (m_period !== 32'd7) begin n_err++; $display("FAIL b2b_period: got %0d want 7", m_period); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %0b want 0", overrun); end
    tick();
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %0b want 0", m_valid); end
  endtask

  task automatic test_glitch_and_reset();
    hold(1'b0, 6);
    sig_in = 1'b1; tick();
    sig_in = 1'b0; tick(); tick();
    n_vec++; if (m_high !== 32'd4) begin n_err++; $display("FAIL gl_prev_high: got %0d want 4", m_high); end
    n_vec++; if (m_period !== 32'd10) begin n_err++; $display("FAIL gl_prev_period: got %0d want 10", m_period); end
    repeat (4) tick();
    m_ready = 1'b0;
    sig_in = 1'b1; tick();
    sig_in = 1'b0; tick(); tick();
    n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL gl_valid: got %0b want 1", m_valid); end
    n_vec++; if (m_high !== 32'd1) begin n_err++; $display("FAIL gl_high: got %0d want 1", m_high); end
    n_vec++; if (m_period !== 32'd7) begin n_err++; $display("FAIL gl_period: got %0d want 7", m_period); end
    tick(); tick();
    rst = 1'b1; tick();
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %0b want 0", m_valid); end
    n_vec++; if (m_period !== 32'd0) begin n_err++; $display("FAIL mid_rst_period: got %0d want 0", m_period); end
    rst = 1'b0;
    tick(); tick(); tick();
    sig_in = 1'b1; tick();
    sig_in = 1'b0; tick(); tick();
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_one_rise: got %0b want 0", m_valid); end
    repeat (4) tick();
    sig_in = 1'b1; tick();
    sig_in = 1'b0; tick(); tick();
    n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL post_rst_valid: got %0b want 1", m_valid); end
    n_vec++; if (m_high !== 32'd1) begin n_err++; $display("FAIL post_rst_high: got %0d want 1", m_high); end
    n_vec++; if (m_period !== 32'd7) begin n_err++; $display("FAIL post_rst_period: got %0d want 7", m_period); end
  endtask

  task automatic test_integration();
    m_ready = 1'b1;
    hold(1'b0, 5);
    for (int i = 0; i < 4; i++) begin
      sig_in = 1'b1;
      tick(); tick(); tick();
      if (i > 0) begin
        n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL gen_valid[%0d]: got %0b want 1", i, m_valid); end
        n_vec++; if (m_high !== 32'd10) begin n_err++; $display("FAIL gen_high[%0d]: got %0d want 10", i, m_high); end
        n_vec++; if (m_period !== 32'd31) begin n_err++; $display("FAIL gen_period[%0d]: got %0d want 31", i, m_period); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL gen_overrun[%0d]: got %0b want 0", i, overrun); end
      end
      repeat (7) tick();
      hold(1'b0, 21);
    end
  endtask

  task automatic test_timeout();
    tick();
    rst2 = 1'b0;
    tick(); tick(); tick();
    sig2 = 1'b1;
    repeat (22) tick();
    n_vec++; if (to2 !== 1'b0) begin n_err++; $display("FAIL to_early: got %0b want 0", to2); end
    tick();
    n_vec++; if (to2 !== 1'b1) begin n_err++; $display("FAIL to_pulse: got %0b want 1", to2); end
    tick();
    n_vec++; if (to2 !== 1'b0) begin n_err++; $display("FAIL to_one_cycle: got %0b want 0", to2); end
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (to2 !== 1'b0 || valid2 !== 1'b0) begin n_err++; $display("FAIL to_quiet[%0d]: got to=%0b valid=%0b want 0/0", i, to2, valid2); end
      tick();
    end
    hold2(1'b0, 5);
    hold2(1'b1, 3);
    hold2(1'b0, 5);
    sig2 = 1'b1;
    tick(); tick();
    n_vec++; if (valid2 !== 1'b0) begin n_err++; $display("FAIL to_recover_early: got %0b want 0", valid2); end
    tick();
    n_vec++; if (valid2 !== 1'b1) begin n_err++; $display("FAIL to_recover_valid: got %0b want 1", valid2); end
    n_vec++; if (high2 !== 32'd3) begin n_err++; $display("FAIL to_recover_high: got %0d want 3", high2); end
    n_vec++; if (period2 !== 32'd8) begin n_err++; $display("FAIL to_recover_period: got %0d want 8", period2); end
    ready2 = 1'b1;
    hold2(1'b0, 17);
    sig2 = 1'b1;
    tick(); tick(); tick();
    n_vec++; if (valid2 !== 1'b1) begin n_err++; $display("FAIL edge_valid: got %0b want 1", valid2); end
    n_vec++; if (period2 !== 32'd20) begin n_err++; $display("FAIL edge_period: got %0d want 20", period2); end
    n_vec++; if (to2 !== 1'b0) begin n_err++; $display("FAIL edge_no_timeout: got %0b want 0", to2); end
    tick();
    n_vec++; if (to2 !== 1'b0) begin n_err++; $display("FAIL edge_no_timeout_late: got %0b want 0", to2); end
  endtask

  initial begin
    rst2 = 1'b1; sig2 = 1'b0; ready2 = 1'b0;
    test_reset();
    test_first_result();
    test_overrun();
    test_back_to_back();
    test_glitch_and_reset();
    test_integration();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
